// File: rtl/adma_sequencer_pkg.sv
// Shared types for the ADMA2 descriptor-chain sequencer.
package adma_sequencer_pkg;

  localparam int unsigned ADDR_W            = 64;
  localparam int unsigned LEN_W             = 17;
  localparam int unsigned DESC_W            = 96;
  localparam int unsigned DESC_BYTES_DEF    = 12;
  localparam int unsigned FETCH_TIMEOUT_DEF = 16;

  // Sequencer state codes; also reported through adma_error_state.
  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_FDS  = 2'b01,
    ST_CADR = 2'b10,
    ST_TFR  = 2'b11
  } adma_state_e;

  // Descriptor action field encodings.
  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } adma_act_e;

  // 96-bit descriptor: valid[0] end[1] int[2] act[5:4] length[31:16] address[95:32].
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [15:0]       length;
    logic [9:0]        rsvd_hi;
    adma_act_e         act;
    logic              rsvd_lo;
    logic              irq;
    logic              last;
    logic              valid;
  } adma_desc_t;

  // Error code reported for fetch timeouts and invalid descriptors.
  localparam logic [1:0] ERR_CODE_FETCH = 2'b01;

endpackage

// File: rtl/adma_sequencer_if.sv
// Fetch-unit and transfer-engine handshake bundle for the ADMA sequencer.
interface adma_sequencer_if;
  import adma_sequencer_pkg::*;

  logic              fetch_start;
  logic [ADDR_W-1:0] fetch_address;
  logic              fetch_start_ack;
  logic              fetch_done;
  logic [DESC_W-1:0] fetch_descriptor;
  logic              tfr_start;
  logic [ADDR_W-1:0] tfr_address;
  logic [LEN_W-1:0]  tfr_length;
  logic              tfr_done;

  modport master (
    output fetch_start, fetch_address, tfr_start, tfr_address, tfr_length,
    input  fetch_start_ack, fetch_done, fetch_descriptor, tfr_done
  );

  modport slave (
    input  fetch_start, fetch_address, tfr_start, tfr_address, tfr_length,
    output fetch_start_ack, fetch_done, fetch_descriptor, tfr_done
  );
endinterface

// File: rtl/adma_fetch_timer.sv
// Counts descriptor-fetch cycles and flags the last allowed one.
module adma_fetch_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_c_o
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  // Expired on the TIMEOUT-th enabled cycle, so the caller leaves on that edge.
  assign expired_c_o = en_i && (count_q == CW'(TIMEOUT - 1));

  // Next count: clear wins, saturate once expired.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_c_o) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end
endmodule

// File: rtl/adma_sequencer.sv
// ADMA2 descriptor-chain controller: fetches, decodes and dispatches descriptors.
module adma_sequencer
  import adma_sequencer_pkg::*;
#(
  parameter int unsigned DESC_BYTES    = DESC_BYTES_DEF,
  parameter int unsigned FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              adma_start,
  input  logic              adma_stop,
  input  logic [ADDR_W-1:0] adma_sys_addr,
  adma_sequencer_if.master  bus,
  output logic              adma_busy,
  output logic              adma_int,
  output logic              adma_xfer_complete,
  output logic              adma_error_int,
  output logic [1:0]        adma_error_state,
  output logic [ADDR_W-1:0] adma_desc_ptr
);
  adma_state_e       state_q, state_d;
  adma_desc_t        desc_q, desc_d;
  logic [ADDR_W-1:0] desc_ptr_q, desc_ptr_d;
  logic [ADDR_W-1:0] tfr_addr_q, tfr_addr_d;
  logic [LEN_W-1:0]  tfr_len_q, tfr_len_d;
  logic [1:0]        err_state_q, err_state_d;
  logic ack_seen_q, ack_seen_d;
  logic fetch_start_q, fetch_start_d;
  logic tfr_start_q, tfr_start_d;
  logic int_q, int_d;
  logic cmpl_q, cmpl_d;
  logic err_int_q, err_int_d;
  logic busy_q, busy_d;
  logic fetch_expired_c;
  logic unused_rsvd;

  adma_fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_timer (
    .clk_i      (CLK),
    .rst_n_i    (RESET_N),
    .clear_i    (state_q != ST_FDS),
    .en_i       (state_q == ST_FDS),
    .expired_c_o(fetch_expired_c)
  );

  assign unused_rsvd        = ^{desc_q.rsvd_hi, desc_q.rsvd_lo};
  assign bus.fetch_start    = fetch_start_q;
  assign bus.fetch_address  = desc_ptr_q;
  assign bus.tfr_start      = tfr_start_q;
  assign bus.tfr_address    = tfr_addr_q;
  assign bus.tfr_length     = tfr_len_q;
  assign adma_busy          = busy_q;
  assign adma_int           = int_q;
  assign adma_xfer_complete = cmpl_q;
  assign adma_error_int     = err_int_q;
  assign adma_error_state   = err_state_q;
  assign adma_desc_ptr      = desc_ptr_q;

  // Next-state and registered-output logic; abort overrides everything last.
  always_comb begin
    state_d       = state_q;
    desc_d        = desc_q;
    desc_ptr_d    = desc_ptr_q;
    tfr_addr_d    = tfr_addr_q;
    tfr_len_d     = tfr_len_q;
    err_state_d   = err_state_q;
    ack_seen_d    = 1'b0;
    fetch_start_d = 1'b0;
    tfr_start_d   = 1'b0;
    int_d         = 1'b0;
    cmpl_d        = 1'b0;
    err_int_d     = 1'b0;

    unique case (state_q)
      ST_STOP: begin
        if (adma_start && !adma_stop) begin
          desc_ptr_d    = adma_sys_addr;
          err_state_d   = 2'b00;
          fetch_start_d = 1'b1;
          state_d       = ST_FDS;
        end
      end
      ST_FDS: begin
        // Done is only trusted after the fetch unit acknowledged the start.
        ack_seen_d = ack_seen_q | bus.fetch_start_ack;
        if (ack_seen_q && bus.fetch_done) begin
          desc_d  = adma_desc_t'(bus.fetch_descriptor);
          state_d = ST_CADR;
        end else if (fetch_expired_c) begin
          err_int_d   = 1'b1;
          err_state_d = ERR_CODE_FETCH;
          state_d     = ST_STOP;
        end
      end
      ST_CADR: begin
        if (!desc_q.valid) begin
          err_int_d   = 1'b1;
          err_state_d = ERR_CODE_FETCH;
          state_d     = ST_STOP;
        end else if (desc_q.act == ACT_TRAN) begin
          tfr_addr_d  = desc_q.address;
          tfr_len_d   = (desc_q.length == 16'd0) ? LEN_W'(32'h1_0000) : LEN_W'(desc_q.length);
          tfr_start_d = 1'b1;
          state_d     = ST_TFR;
        end else begin
          desc_ptr_d = (desc_q.act == ACT_LINK) ? desc_q.address
                                                : desc_ptr_q + ADDR_W'(DESC_BYTES);
          int_d = desc_q.irq;
          if (desc_q.last) begin
            cmpl_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            fetch_start_d = 1'b1;
            state_d       = ST_FDS;
          end
        end
      end
      ST_TFR: begin
        if (bus.tfr_done) begin
          desc_ptr_d = desc_ptr_q + ADDR_W'(DESC_BYTES);
          int_d      = desc_q.irq;
          if (desc_q.last) begin
            cmpl_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            fetch_start_d = 1'b1;
            state_d       = ST_FDS;
          end
        end
      end
    endcase

    if (adma_stop && (state_q != ST_STOP)) begin
      state_d       = ST_STOP;
      err_state_d   = state_q;
      desc_d        = desc_q;
      desc_ptr_d    = desc_ptr_q;
      tfr_addr_d    = tfr_addr_q;
      tfr_len_d     = tfr_len_q;
      ack_seen_d    = 1'b0;
      fetch_start_d = 1'b0;
      tfr_start_d   = 1'b0;
      int_d         = 1'b0;
      cmpl_d        = 1'b0;
      err_int_d     = 1'b0;
    end

    busy_d = (state_d != ST_STOP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q       <= ST_STOP;
      desc_q        <= '0;
      desc_ptr_q    <= '0;
      tfr_addr_q    <= '0;
      tfr_len_q     <= '0;
      err_state_q   <= '0;
      ack_seen_q    <= 1'b0;
      fetch_start_q <= 1'b0;
      tfr_start_q   <= 1'b0;
      int_q         <= 1'b0;
      cmpl_q        <= 1'b0;
      err_int_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      desc_q        <= desc_d;
      desc_ptr_q    <= desc_ptr_d;
      tfr_addr_q    <= tfr_addr_d;
      tfr_len_q     <= tfr_len_d;
      err_state_q   <= err_state_d;
      ack_seen_q    <= ack_seen_d;
      fetch_start_q <= fetch_start_d;
      tfr_start_q   <= tfr_start_d;
      int_q         <= int_d;
      cmpl_q        <= cmpl_d;
      err_int_q     <= err_int_d;
      busy_q        <= busy_d;
    end
  end
endmodule

// File: tb/tb_adma_sequencer.sv
// Directed bench for adma_sequencer: scenario table plus a reset-in-transfer sequence.
module tb_adma_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        adma_start, adma_stop;
  logic [63:0] adma_sys_addr;
  logic        adma_busy, adma_int, adma_xfer_complete, adma_error_int;
  logic [1:0]  adma_error_state;
  logic [63:0] adma_desc_ptr;
  int checks = 0;
  int failures = 0;

  adma_sequencer_if bus ();

  adma_sequencer dut (
    .CLK               (clk),
    .RESET_N           (rst_n),
    .adma_start        (adma_start),
    .adma_stop         (adma_stop),
    .adma_sys_addr     (adma_sys_addr),
    .bus               (bus),
    .adma_busy         (adma_busy),
    .adma_int          (adma_int),
    .adma_xfer_complete(adma_xfer_complete),
    .adma_error_int    (adma_error_int),
    .adma_error_state  (adma_error_state),
    .adma_desc_ptr     (adma_desc_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sys;
    logic [95:0] d0, d1, d2;
    int          no_ack;
    int          stop_tfr;
    int          e_nf;
    logic [63:0] f0, f1, f2;
    int          e_ntfr;
    logic [63:0] e_taddr;
    logic [16:0] e_tlen;
    int          e_int, e_cmpl, e_both, e_err;
    logic [1:0]  e_est;
    logic [63:0] e_ptr;
    int          e_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [95:0] mk(input logic v, input logic l, input logic i,
                                     input logic [1:0] a, input logic [15:0] len,
                                     input logic [63:0] addr);
    return {addr, len, 10'b0, a, 1'b0, i, l, v};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Plays fetch unit and transfer engine for one chain, then compares the tally.
  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0] fa[3];
    logic [63:0] taddr = '0;
    logic [16:0] tlen = '0;
    int nf = 0, ntfr = 0, nint = 0, ncmpl = 0, nboth = 0, nerr = 0;
    int k = 0, cyc = 0, c0 = -1, cerr = -1;
    bit fph = 1'b0, fin = 1'b0;
    fa[0] = '0; fa[1] = '0; fa[2] = '0;
    adma_sys_addr = v.sys;
    adma_start = 1'b1;
    @(negedge clk);
    adma_start = 1'b0;
    while (!fin && cyc < 200) begin
      bus.fetch_start_ack = 1'b0;
      bus.tfr_done = 1'b0;
      adma_stop = 1'b0;
      if (fph) begin
        bus.fetch_done = 1'b1;
        bus.fetch_descriptor = (k == 0) ? v.d0 : (k == 1) ? v.d1 : v.d2;
        k++;
        fph = 1'b0;
      end
      if (bus.fetch_start) begin
        if (nf < 3) fa[nf] = bus.fetch_address;
        nf++;
        if (c0 < 0) c0 = cyc;
        if (v.no_ack == 0) begin
          bus.fetch_start_ack = 1'b1;
          bus.fetch_done = 1'b0;
          fph = 1'b1;
        end
      end
      if (bus.tfr_start) begin
        ntfr++;
        taddr = bus.tfr_address;
        tlen = bus.tfr_length;
        if (v.stop_tfr != 0) adma_stop = 1'b1;
        else bus.tfr_done = 1'b1;
      end
      if (adma_int) nint++;
      if (adma_xfer_complete) ncmpl++;
      if (adma_int && adma_xfer_complete) nboth++;
      if (adma_error_int) begin
        nerr++;
        if (cerr < 0) cerr = cyc;
      end
      if (!adma_busy) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk($sformatf("v%0d_finished", idx), 96'(fin), 96'(1));
    chk($sformatf("v%0d_nfetch", idx), 96'(nf), 96'(v.e_nf));
    if (v.e_nf > 0) chk($sformatf("v%0d_faddr0", idx), 96'(fa[0]), 96'(v.f0));
    if (v.e_nf > 1) chk($sformatf("v%0d_faddr1", idx), 96'(fa[1]), 96'(v.f1));
    if (v.e_nf > 2) chk($sformatf("v%0d_faddr2", idx), 96'(fa[2]), 96'(v.f2));
    chk($sformatf("v%0d_ntfr", idx), 96'(ntfr), 96'(v.e_ntfr));
    if (v.e_ntfr > 0) begin
      chk($sformatf("v%0d_taddr", idx), 96'(taddr), 96'(v.e_taddr));
      chk($sformatf("v%0d_tlen", idx), 96'(tlen), 96'(v.e_tlen));
    end
    chk($sformatf("v%0d_int", idx), 96'(nint), 96'(v.e_int));
    chk($sformatf("v%0d_cmpl", idx), 96'(ncmpl), 96'(v.e_cmpl));
    chk($sformatf("v%0d_int_cmpl_same", idx), 96'(nboth), 96'(v.e_both));
    chk($sformatf("v%0d_err", idx), 96'(nerr), 96'(v.e_err));
    chk($sformatf("v%0d_err_state", idx), 96'(adma_error_state), 96'(v.e_est));
    chk($sformatf("v%0d_desc_ptr", idx), 96'(adma_desc_ptr), 96'(v.e_ptr));
    chk($sformatf("v%0d_busy", idx), 96'(adma_busy), 96'(0));
    if (v.e_lat >= 0) chk($sformatf("v%0d_timeout_lat", idx), 96'(cerr - c0), 96'(v.e_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    adma_start = 1'b0;
    adma_stop = 1'b0;
    adma_sys_addr = '0;
    bus.fetch_start_ack = 1'b0;
    bus.fetch_done = 1'b1;
    bus.fetch_descriptor = '0;
    bus.tfr_done = 1'b0;

    vecs[0] = '{64'h0, mk(1,1,1,2'b10,16'h0200,64'h1000), '0, '0, 0, 0,
                1, 64'h0, 64'h0, 64'h0, 1, 64'h1000, 17'd512, 1, 1, 1, 0, 2'b00, 64'hC, -1};
    vecs[1] = '{64'h100, mk(1,0,0,2'b10,16'h0010,64'h2000), mk(1,0,0,2'b11,16'h0,64'h8000),
                mk(1,1,0,2'b10,16'h0020,64'h3000), 0, 0,
                3, 64'h100, 64'h10C, 64'h8000, 2, 64'h3000, 17'h20, 0, 1, 0, 0, 2'b00, 64'h800C, -1};
    vecs[2] = '{64'h40, mk(0,1,1,2'b10,16'h5,64'h5000), '0, '0, 0, 0,
                1, 64'h40, 64'h0, 64'h0, 0, 64'h0, 17'h0, 0, 0, 0, 1, 2'b01, 64'h40, -1};
    vecs[3] = '{64'h200, mk(1,1,0,2'b10,16'h0,64'h7000), '0, '0, 0, 0,
                1, 64'h200, 64'h0, 64'h0, 1, 64'h7000, 17'h10000, 0, 1, 0, 0, 2'b00, 64'h20C, -1};
    vecs[4] = '{64'h300, mk(1,1,0,2'b10,16'h4,64'h6000), '0, '0, 1, 0,
                1, 64'h300, 64'h0, 64'h0, 0, 64'h0, 17'h0, 0, 0, 0, 1, 2'b01, 64'h300, 16};
    vecs[5] = '{64'h400, mk(1,1,1,2'b10,16'h8,64'h9000), '0, '0, 0, 1,
                1, 64'h400, 64'h0, 64'h0, 1, 64'h9000, 17'h8, 0, 0, 0, 0, 2'b11, 64'h400, -1};
    vecs[6] = '{64'h500, mk(1,0,1,2'b00,16'h0,64'h0), mk(1,1,1,2'b11,16'h0,64'hA000), '0, 0, 0,
                2, 64'h500, 64'h50C, 64'h0, 0, 64'h0, 17'h0, 2, 1, 1, 0, 2'b00, 64'hA000, -1};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFF8, mk(1,1,0,2'b01,16'h0,64'h0), '0, '0, 0, 0,
                1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 0, 64'h0, 17'h0, 0, 1, 0, 0, 2'b00,
                64'h4, -1};

    repeat (3) @(negedge clk);
    chk("reset_busy", 96'(adma_busy), 96'(0));
    chk("reset_desc_ptr", 96'(adma_desc_ptr), 96'(0));
    chk("reset_fetch_start", 96'(bus.fetch_start), 96'(0));
    chk("reset_err_state", 96'(adma_error_state), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
      @(negedge clk);
    end

    // Reset asserted while the transfer engine is busy.
    adma_sys_addr = 64'h600;
    adma_start = 1'b1;
    @(negedge clk);
    adma_start = 1'b0;
    n = 0;
    while (!bus.fetch_start && n < 20) begin @(negedge clk); n++; end
    chk("rst_seq_fetch_start", 96'(bus.fetch_start), 96'(1));
    bus.fetch_start_ack = 1'b1;
    bus.fetch_done = 1'b0;
    @(negedge clk);
    bus.fetch_start_ack = 1'b0;
    bus.fetch_done = 1'b1;
    bus.fetch_descriptor = mk(1,1,1,2'b10,16'h4,64'hB000);
    n = 0;
    while (!bus.tfr_start && n < 20) begin @(negedge clk); n++; end
    chk("rst_seq_tfr_start", 96'(bus.tfr_start), 96'(1));
    chk("rst_seq_tfr_addr", 96'(bus.tfr_address), 96'(64'hB000));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_seq_busy", 96'(adma_busy), 96'(0));
    chk("rst_seq_desc_ptr", 96'(adma_desc_ptr), 96'(0));
    chk("rst_seq_tfr_addr0", 96'(bus.tfr_address), 96'(0));
    chk("rst_seq_tfr_len0", 96'(bus.tfr_length), 96'(0));
    chk("rst_seq_tfr_start0", 96'(bus.tfr_start), 96'(0));
    rst_n = 1'b1;
    bus.tfr_done = 1'b1;
    @(negedge clk);
    bus.tfr_done = 1'b0;
    chk("rst_seq_late_done_int", 96'(adma_int), 96'(0));
    chk("rst_seq_late_done_cmpl", 96'(adma_xfer_complete), 96'(0));
    chk("rst_seq_late_done_ptr", 96'(adma_desc_ptr), 96'(0));
    @(negedge clk);
    chk("rst_seq_idle_busy", 96'(adma_busy), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
